// File: rtl/anaio_path_sequencer.sv
// Break-before-make sequencer for the analog IO pad switches (VESD0..3, VRES0..3).
// At most one switch enable is ever high; every path change passes through an all-off window.
module anaio_path_sequencer #(
    parameter int NUM_PATHS     = 8,
    parameter int SEL_W         = 3,
    parameter int BREAK_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_en,
    input  logic [SEL_W-1:0]     req_sel,
    input  logic                 force_off,
    output logic [NUM_PATHS-1:0] path_en,
    output logic [SEL_W-1:0]     active_sel,
    output logic                 active_vld,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE, ST_SETTLE} state_t;

    localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_PATHS_W = (SEL_W + 1)'(NUM_PATHS);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 conn_q, conn_d;
    logic [NUM_PATHS-1:0] path_en_q, path_en_d;
    logic [SEL_W-1:0]     active_sel_q, active_sel_d;
    logic                 active_vld_q, active_vld_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 sel_oob;
    logic [NUM_PATHS-1:0] sel_onehot;

    assign req_ready  = (state_q == ST_IDLE) && !force_off;
    assign accept     = req_valid && req_ready;
    assign sel_oob    = {1'b0, req_sel} >= NUM_PATHS_W;
    assign sel_onehot = {{(NUM_PATHS-1){1'b0}}, 1'b1} << sel_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        sel_d        = sel_q;
        conn_d       = conn_q;
        path_en_d    = path_en_q;
        active_sel_d = active_sel_q;
        active_vld_d = active_vld_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        // Emergency disconnect overrides everything and parks the FSM in a held BREAK.
        if (force_off) begin
            state_d      = ST_BREAK;
            timer_d      = BREAK_LOAD;
            conn_d       = 1'b0;
            path_en_d    = '0;
            active_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_en && sel_oob) begin
                            err_d = 1'b1;
                        end else if (req_en && active_vld_q && (req_sel == active_sel_q)) begin
                            done_d = 1'b1;
                        end else if (!req_en && (path_en_q == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d      = ST_BREAK;
                            timer_d      = BREAK_LOAD;
                            sel_d        = req_sel;
                            conn_d       = req_en;
                            path_en_d    = '0;
                            active_vld_d = 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (timer_q == '0) begin
                        if (conn_q) begin
                            state_d   = ST_MAKE;
                            path_en_d = sel_onehot;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_MAKE: begin
                    state_d = ST_SETTLE;
                    timer_d = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (timer_q == '0) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        active_vld_d = 1'b1;
                        active_sel_d = sel_q;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    path_en_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            sel_q        <= '0;
            conn_q       <= 1'b0;
            path_en_q    <= '0;
            active_sel_q <= '0;
            active_vld_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            conn_q       <= conn_d;
            path_en_q    <= path_en_d;
            active_sel_q <= active_sel_d;
            active_vld_q <= active_vld_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign path_en    = path_en_q;
    assign active_sel = active_sel_q;
    assign active_vld = active_vld_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_anaio_path_sequencer.sv
// Scoreboard bench for anaio_path_sequencer: a timeline model predicts each cycle's
// switch enables and the done/err pulse of every accepted request.
module tb_anaio_path_sequencer;

    localparam int NP  = 6;
    localparam int SW  = 3;
    localparam int BRK = 4;
    localparam int SET = 16;
    localparam int CW  = 8;
    localparam int INF = 1000000000;

    logic          clk, rst_n, req_valid, req_ready, req_en, force_off;
    logic [SW-1:0] req_sel, active_sel;
    logic [NP-1:0] path_en;
    logic          active_vld, busy, done, err;

    anaio_path_sequencer #(
        .NUM_PATHS(NP), .SEL_W(SW), .BREAK_CYCLES(BRK), .SETTLE_CYCLES(SET), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_en(req_en), .req_sel(req_sel), .force_off(force_off), .path_en(path_en),
        .active_sel(active_sel), .active_vld(active_vld), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int due;
        bit is_err;
    } ev_t;

    ev_t           evq[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    // Settled connection, and the one sequence (request or forced break) in flight.
    bit            m_vld = 0;
    logic [SW-1:0] m_sel = '0;
    bit            seq_act = 0;
    bit            seq_conn = 0;
    logic [SW-1:0] seq_sel = '0;
    int            seq_start = 0;
    int            seq_make = INF;
    int            seq_end = INF;
    bit            prev_force = 0;
    bit            exp_ready = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    function automatic void fail_now(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        n_fail++;
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    endfunction

    function automatic logic [NP-1:0] onehot(input logic [SW-1:0] s);
        logic [NP-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic bit model_idle(input int c);
        return !(seq_act && c >= seq_start && c < seq_end);
    endfunction

    function automatic void expect_at(input int c, output logic [NP-1:0] p, output bit v,
                                      output logic [SW-1:0] s, output bit b);
        v = m_vld;
        s = m_sel;
        p = m_vld ? onehot(m_sel) : '0;
        b = 0;
        if (seq_act && c >= seq_start) begin
            if (c >= seq_end) begin
                v = seq_conn;
                if (seq_conn) s = seq_sel;
                p = seq_conn ? onehot(seq_sel) : '0;
            end else begin
                b = 1;
                v = 0;
                p = (seq_conn && c >= seq_make) ? onehot(seq_sel) : '0;
            end
        end
    endfunction

    function automatic void commit(input int c);
        if (seq_act && c >= seq_end) begin
            m_vld = seq_conn;
            if (seq_conn) m_sel = seq_sel;
            seq_act = 0;
        end
    endfunction

    function automatic void model_reset();
        m_vld = 0;
        m_sel = '0;
        seq_act = 0;
        seq_end = INF;
        seq_make = INF;
        prev_force = 0;
        evq.delete();
    endfunction

    // Request presented in cycle c is taken at the following edge.
    function automatic void apply_req(input bit en, input logic [SW-1:0] s, input int c);
        if (en && int'(s) >= NP) begin
            evq.push_back('{due: c + 1, is_err: 1'b1});
        end else if ((en && m_vld && s == m_sel) || (!en && !m_vld)) begin
            evq.push_back('{due: c + 1, is_err: 1'b0});
        end else begin
            seq_act   = 1;
            seq_start = c + 1;
            seq_conn  = en;
            seq_sel   = s;
            seq_make  = en ? c + 1 + BRK : INF;
            seq_end   = en ? c + BRK + SET + 2 : c + BRK + 1;
            evq.push_back('{due: seq_end, is_err: 1'b0});
        end
    endfunction

    // Monitor: outputs of cycle c at +1, the combinational ready at +4.
    always @(posedge clk) begin
        logic [NP-1:0] ep;
        bit            ev, eb;
        logic [SW-1:0] es;
        ev_t           e;
        #1;
        expect_at(cyc, ep, ev, es, eb);
        chk("path_en", 32'(path_en), 32'(ep));
        chk("path_onehot0", 32'($countones(path_en) <= 1), 32'(1));
        chk("active_vld", 32'(active_vld), 32'(ev));
        if (ev) chk("active_sel", 32'(active_sel), 32'(es));
        chk("busy", 32'(busy), 32'(eb));
        while (evq.size() > 0 && evq[0].due < cyc) begin
            fail_now("pulse_missing", 32'(cyc), 32'(evq[0].due));
            void'(evq.pop_front());
        end
        if (done || err) begin
            if (evq.size() == 0) begin
                fail_now("unexpected_pulse", {30'd0, done, err}, 32'(0));
            end else begin
                e = evq.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.due));
                chk("err_pulse", 32'(err), 32'(e.is_err));
                chk("done_pulse", 32'(done), 32'(!e.is_err));
            end
        end
        #3;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
    end

    task automatic step(input bit v, input bit en, input logic [SW-1:0] s, input bit f,
                        output bit accepted);
        bit idle_c;
        @(posedge clk);
        #2;
        commit(cyc);
        req_valid = v;
        req_en    = en;
        req_sel   = s;
        force_off = f;
        accepted  = 0;
        idle_c    = model_idle(cyc);
        exp_ready = idle_c && !f;
        if (f) begin
            while (evq.size() > 0 && evq[$].due > cyc) void'(evq.pop_back());
            seq_act   = 1;
            seq_start = cyc + 1;
            seq_conn  = 0;
            seq_make  = INF;
            seq_end   = INF;
        end else begin
            if (prev_force) begin
                seq_end = cyc + BRK;
                evq.push_back('{due: seq_end, is_err: 1'b0});
            end else if (v && idle_c) begin
                accepted = 1;
                apply_req(en, s, cyc);
            end
        end
        prev_force = f;
    endtask

    task automatic idle_steps(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, a);
    endtask

    task automatic req(input bit en, input logic [SW-1:0] s);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            step(1, en, s, 0, acc);
            n++;
        end
        chk("req_accepted", 32'(acc), 32'(1));
    endtask

    task automatic wait_idle();
        bit a;
        int n;
        n = 0;
        while ((evq.size() != 0 || !model_idle(cyc)) && n < 300) begin
            step(0, 0, '0, 0, a);
            n++;
        end
        chk("idle_reached", 32'(n < 300), 32'(1));
    endtask

    task automatic wait_until(input int target);
        bit a;
        int n;
        n = 0;
        while (cyc < target && n < 300) begin
            step(0, 0, '0, 0, a);
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        exp_ready = 1;
        #1;
        chk("rst_path_en", 32'(path_en), 32'(0));
        chk("rst_active_vld", 32'(active_vld), 32'(0));
        chk("rst_active_sel", 32'(active_sel), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        idle_steps(3);
        rst_n = 1'b1;
    endtask

    initial begin
        bit            pend, pend_en, fval, acc;
        logic [SW-1:0] pend_sel;
        int            force_left;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_en    = 1'b0;
        req_sel   = '0;
        force_off = 1'b0;
        idle_steps(3);
        rst_n = 1'b1;
        idle_steps(2);

        // Connect VRES1, then move to VESD2, then repeat VESD2.
        req(1, 3'd5);
        wait_idle();
        chk("conn5_vld", 32'(active_vld), 32'(1));
        chk("conn5_sel", 32'(active_sel), 32'(5));
        chk("conn5_path", 32'(path_en), 32'(6'b100000));
        req(1, 3'd2);
        wait_idle();
        chk("conn2_path", 32'(path_en), 32'(6'b000100));
        req(1, 3'd2);
        wait_idle();
        chk("same2_path", 32'(path_en), 32'(6'b000100));

        // Out-of-range selects on a 6-path build.
        req(1, 3'd7);
        wait_idle();
        req(1, 3'd6);
        wait_idle();
        chk("err_path_kept", 32'(path_en), 32'(6'b000100));
        chk("err_vld_kept", 32'(active_vld), 32'(1));

        // Emergency disconnect during SETTLE of VESD3.
        req(1, 3'd3);
        wait_until(seq_make + 3);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, acc);
        wait_idle();
        chk("force_vld", 32'(active_vld), 32'(0));
        chk("force_path", 32'(path_en), 32'(0));

        req(0, 3'd0);
        wait_idle();

        // Asynchronous reset mid-BREAK and mid-SETTLE.
        req(1, 3'd1);
        wait_until(seq_start + 1);
        do_reset();
        idle_steps(2);
        req(1, 3'd4);
        wait_until(seq_make + 5);
        do_reset();
        idle_steps(2);

        pend = 0;
        pend_en = 0;
        pend_sel = '0;
        force_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (!pend && $urandom_range(0, 99) < 25) begin
                pend = 1;
                pend_en = ($urandom_range(0, 3) != 0);
                pend_sel = (m_vld && $urandom_range(0, 2) == 0) ? m_sel : 3'($urandom_range(0, 7));
            end
            if (force_left == 0 && $urandom_range(0, 99) < 2) force_left = $urandom_range(1, 12);
            fval = (force_left > 0);
            if (force_left > 0) force_left--;
            step(pend, pend_en, pend_sel, fval, acc);
            if (acc) pend = 0;
        end

        wait_idle();
        idle_steps(3);
        chk("queue_drained", 32'(evq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
